sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single 32 MB SDRAM controller between two requesters: the N64 cart-bus read path (latency-critical, read-only) and the host/loader port (read and write, used for ROM upload and debug readback).
- Drives the controller's level-held readport/writeport req/ack handshake, and presents the same four-phase handshake to each requester.
- Cart has fixed priority, bounded by a starvation limit for the host.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 16, data width on all ports.
- STARVE_LIMIT, 4, consecutive cart grants allowed while a host request is pending; 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cart_rd  in  1  cart read request, level, held until cart_ack.
- cart_addr  in  ADDR_W  cart read address.
- cart_data  out  DATA_W  cart read data, valid while cart_ack=1.
- cart_ack  out  1  cart handshake acknowledge.
- host_rd  in  1  host read request, level.
- host_wr  in  1  host write request, level.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_rdata  out  DATA_W  host read data, valid while host_ack=1.
- host_ack  out  1  host handshake acknowledge.
- mem_rd  out  1  to controller readport_rd.
- mem_raddr  out  ADDR_W  to controller readport_addr.
- mem_rdata  in  DATA_W  from controller readport_data.
- mem_rack  in  1  from controller readport_ack.
- mem_wr  out  1  to controller writeport_wr.
- mem_waddr  out  ADDR_W  to controller writeport_addr.
- mem_wdata  out  DATA_W  to controller writeport_data.
- mem_wack  in  1  from controller writeport_ack.
- owner  out  2  current grant: 0 none, 1 cart, 2 host read, 3 host write.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, starve counter 0. If reset lands mid-transaction, the mem requests drop immediately. IDLE must not grant while mem_rack or mem_wack is still 1.
- States: IDLE -> ISSUE -> HOLD -> RELEASE -> IDLE.
- IDLE: grant is evaluated when (cart_rd | host_rd | host_wr) and !mem_rack and !mem_wack.
  - Winner is cart, unless host is pending and starve_cnt == STARVE_LIMIT, in which case host wins.
  - Host with host_wr=1 and host_rd=1 together is treated as a write.
  - On the grant edge, latch address and wdata into mem_*addr/mem_wdata, set owner, and raise mem_rd or mem_wr. Go to ISSUE.
  - The mem request is therefore high 1 cycle after the first sampled request.
- Starve counter:
  - +1 on each cart grant while host is pending (saturates at STARVE_LIMIT).
  - Cleared on a host grant, or in IDLE when the host is not pending.
- ISSUE: hold mem_rd/mem_wr and the latched fields stable. On the cycle the matching mem ack is seen high:
  - For reads, capture mem_rdata into the owner's data register only; the other port's data register is unchanged.
  - If the requester's request is still high, assert the owner's ack next cycle and go to HOLD.
  - If the requester withdrew early (request low at this point), complete the transaction to the controller without an upstream ack, drop the mem request, and go to RELEASE.
- HOLD: owner ack stays 1 and mem request stays high until the owner's request is low. On that cycle:
  - the upstream ack goes low the next cycle;
  - the mem request goes low the same edge;
  - go to RELEASE.
- RELEASE: wait until the matching mem ack is 0, then go to IDLE with owner=0. The earliest next grant is the following cycle.
- Request changes on the non-owner port are ignored until IDLE. cart_ack and host_ack are never 1 simultaneously.
- Controller timing (half-rate SDRAM clock, NOP slots) is opaque: there is no arbiter timeout, and ISSUE waits indefinitely.

Decomposition:
- Package sdram_arb_pkg:
  - state encoding (IDLE=0, ISSUE=1, HOLD=2, RELEASE=3);
  - owner codes (OWN_NONE=0, OWN_CART=1, OWN_HRD=2, OWN_HWR=3).
- One natural sub-module: sdram_arb_pick, combinational winner selection plus registered starve counter. Inputs: requests, starve_cnt, grant strobe. Output: next owner.
- The FSM and datapath latches live in the top module.

Test Plan:
- Single cart read: cart_rd=1, addr 0x0000_1234; model acks after 20 cycles with 0xBEEF. Expect mem_rd high 1 cycle after cart_rd, mem_raddr=0x1234, cart_ack=1 with cart_data=0xBEEF; host_rdata unchanged; owner back to 0 after mem_rack drops.
- Host write: host_wr=1, addr 0x0080_0000, wdata 0xA5A5. Expect mem_wr with those values, host_ack after mem_wack, mem_wr low on the same edge host_wr is seen low.
- Simultaneous cart_rd and host_rd in IDLE: cart granted first, host granted in the IDLE cycle after cart's RELEASE completes.
- Starvation: host_rd held while cart issues back-to-back reads. Expect exactly 4 cart grants, then a host grant; starve_cnt returns to 0.
- Early withdrawal: cart_rd dropped during ISSUE. Expect mem_rd held until mem_rack, no cart_ack pulse, clean return to IDLE.
- Reset mid-write: assert reset in HOLD with mem_wack=1. Expect all outputs 0 next cycle; with host_wr=1 after reset, no new grant until the model drops mem_wack.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the SDRAM port arbiter: FSM states, grant owner codes and
// the width of the host starvation counter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CART = 2'd1;
  localparam logic [1:0] OWN_HRD  = 2'd2;
  localparam logic [1:0] OWN_HWR  = 2'd3;

  // Holds STARVE_LIMIT values up to 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sdram_arb_pick.sv
// Winner selection between the cart and host ports: fixed cart priority,
// overridden once the host has waited STARVE_LIMIT cart grants.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cart_rd,
  input  logic             host_rd,
  input  logic             host_wr,
  input  logic             idle,
  input  logic             grant,
  output logic [1:0]       winner_c,
  output logic [CNT_W-1:0] starve_cnt
);

  logic host_pend;
  logic starved;

  assign host_pend = host_rd | host_wr;
  assign starved   = host_pend && (starve_cnt == CNT_W'(STARVE_LIMIT));

  // A host asserting read and write together is treated as a write.
  always_comb begin
    winner_c = OWN_NONE;
    if (cart_rd && !starved) begin
      winner_c = OWN_CART;
    end else if (host_pend) begin
      winner_c = host_wr ? OWN_HWR : OWN_HRD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (winner_c == OWN_CART) begin
        if (host_pend && (starve_cnt < CNT_W'(STARVE_LIMIT))) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end else if (idle && !host_pend) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller read/write port pair between the cart read path
// and the host port, with four-phase req/ack handshakes on every side.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cart_rd,
  input  logic [ADDR_W-1:0] cart_addr,
  output logic [DATA_W-1:0] cart_data,
  output logic              cart_ack,
  input  logic              host_rd,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rack,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wack,
  output logic [1:0]        owner,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [1:0]        owner_nxt, winner_c;
  logic [DATA_W-1:0] cart_data_nxt, host_rdata_nxt, mem_wdata_nxt;
  logic [ADDR_W-1:0] mem_raddr_nxt, mem_waddr_nxt;
  logic              cart_ack_nxt, host_ack_nxt, mem_rd_nxt, mem_wr_nxt, busy_nxt;
  logic              grant_c, req_live_c, mem_ack_c;
  logic [CNT_W-1:0]  starve_cnt;

  // IDLE never grants while the controller still shows an old ack.
  assign grant_c   = (state == IDLE) && (cart_rd | host_rd | host_wr) && !mem_rack && !mem_wack;
  assign mem_ack_c = (owner == OWN_HWR) ? mem_wack : mem_rack;

  always_comb begin
    case (owner)
      OWN_CART: req_live_c = cart_rd;
      OWN_HRD:  req_live_c = host_rd;
      OWN_HWR:  req_live_c = host_wr;
      default:  req_live_c = 1'b0;
    endcase
  end

  sdram_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk       (clk),
    .reset     (reset),
    .cart_rd   (cart_rd),
    .host_rd   (host_rd),
    .host_wr   (host_wr),
    .idle      (state == IDLE),
    .grant     (grant_c),
    .winner_c  (winner_c),
    .starve_cnt(starve_cnt)
  );

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    cart_data_nxt  = cart_data;
    host_rdata_nxt = host_rdata;
    cart_ack_nxt   = cart_ack;
    host_ack_nxt   = host_ack;
    mem_rd_nxt     = mem_rd;
    mem_wr_nxt     = mem_wr;
    mem_raddr_nxt  = mem_raddr;
    mem_waddr_nxt  = mem_waddr;
    mem_wdata_nxt  = mem_wdata;
    case (state)
      IDLE: begin
        if (grant_c) begin
          owner_nxt = winner_c;
          if (winner_c == OWN_HWR) begin
            mem_wr_nxt    = 1'b1;
            mem_waddr_nxt = host_addr;
            mem_wdata_nxt = host_wdata;
          end else begin
            mem_rd_nxt    = 1'b1;
            mem_raddr_nxt = (winner_c == OWN_CART) ? cart_addr : host_addr;
          end
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack_c) begin
          if (owner == OWN_CART) cart_data_nxt = mem_rdata;
          if (owner == OWN_HRD)  host_rdata_nxt = mem_rdata;
          if (req_live_c) begin
            cart_ack_nxt = (owner == OWN_CART);
            host_ack_nxt = (owner != OWN_CART);
            state_nxt    = HOLD;
          end else begin
            // Requester gave up: finish with the controller silently.
            mem_rd_nxt = 1'b0;
            mem_wr_nxt = 1'b0;
            state_nxt  = RELEASE;
          end
        end
      end
      HOLD: begin
        if (!req_live_c) begin
          cart_ack_nxt = 1'b0;
          host_ack_nxt = 1'b0;
          mem_rd_nxt   = 1'b0;
          mem_wr_nxt   = 1'b0;
          state_nxt    = RELEASE;
        end
      end
      RELEASE: begin
        if (!mem_ack_c) begin
          owner_nxt = OWN_NONE;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      cart_data  <= '0;
      host_rdata <= '0;
      cart_ack   <= 1'b0;
      host_ack   <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_raddr  <= '0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      cart_data  <= cart_data_nxt;
      host_rdata <= host_rdata_nxt;
      cart_ack   <= cart_ack_nxt;
      host_ack   <= host_ack_nxt;
      mem_rd     <= mem_rd_nxt;
      mem_wr     <= mem_wr_nxt;
      mem_raddr  <= mem_raddr_nxt;
      mem_waddr  <= mem_waddr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a simple registered SDRAM
// controller model on the mem side.
module tb_sdram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        cart_rd;
  logic [31:0] cart_addr;
  logic [15:0] cart_data;
  logic        cart_ack;
  logic        host_rd;
  logic        host_wr;
  logic [31:0] host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        host_ack;
  logic        mem_rd;
  logic [31:0] mem_raddr;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_rack  = 1'b0;
  logic        mem_wr;
  logic [31:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic        mem_wack  = 1'b0;
  logic [1:0]  owner;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          rlat, wlat, rcnt = 0, wcnt = 0;
  logic [15:0] rdata_val;
  logic        hold_wack;
  logic        ack_seen, early, saw_rack, grant_seen;

  sdram_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .cart_rd   (cart_rd),
    .cart_addr (cart_addr),
    .cart_data (cart_data),
    .cart_ack  (cart_ack),
    .host_rd   (host_rd),
    .host_wr   (host_wr),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .host_ack  (host_ack),
    .mem_rd    (mem_rd),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_rack  (mem_rack),
    .mem_wr    (mem_wr),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wack  (mem_wack),
    .owner     (owner),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: level ack after a programmable latency, dropped once the request falls.
  always @(posedge clk) begin
    if (mem_rd && !mem_rack) begin
      if (rcnt >= rlat - 1) begin
        mem_rack  <= 1'b1;
        mem_rdata <= rdata_val;
        rcnt      <= 0;
      end else begin
        rcnt <= rcnt + 1;
      end
    end else if (!mem_rd && mem_rack) begin
      mem_rack <= 1'b0;
    end
    if (mem_wr && !mem_wack) begin
      if (wcnt >= wlat - 1) begin
        mem_wack <= 1'b1;
        wcnt     <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else if (!mem_wr && mem_wack && !hold_wack) begin
      mem_wack <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return cart_ack;
      1:       return host_ack;
      2:       return mem_rack;
      3:       return owner == 2'd0;
      4:       return owner != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string tag);
    int n = 0;
    while (!probe(sel) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (probe(sel)) else begin
      errors++;
      $error("FAIL %s: condition not reached after %0d cycles (observed 0, expected 1)", tag, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cart_rd = 1'b0; host_rd = 1'b0; host_wr = 1'b0;
    cart_addr = '0; host_addr = '0; host_wdata = '0;
    rlat = 3; wlat = 3; rdata_val = '0; hold_wack = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_owner",    32'(owner),    32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_mem_rd",   32'(mem_rd),   32'd0);
    check("rst_mem_wr",   32'(mem_wr),   32'd0);
    check("rst_cart_ack", 32'(cart_ack), 32'd0);
    check("rst_host_ack", 32'(host_ack), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single cart read, 20-cycle controller latency
    rlat = 20; rdata_val = 16'hBEEF;
    check("c1_mem_rd_pre", 32'(mem_rd), 32'd0);
    cart_addr = 32'h0000_1234; cart_rd = 1'b1;
    @(negedge clk);
    check("c1_mem_rd",    32'(mem_rd),    32'd1);
    check("c1_mem_raddr", mem_raddr,      32'h0000_1234);
    check("c1_owner",     32'(owner),     32'd1);
    check("c1_busy",      32'(busy),      32'd1);
    wait_for(0, "c1_wait_ack");
    check("c1_cart_data",  32'(cart_data),  32'h0000_BEEF);
    check("c1_host_rdata", 32'(host_rdata), 32'h0000_0000);
    check("c1_host_ack",   32'(host_ack),   32'd0);
    cart_rd = 1'b0;
    @(negedge clk);
    check("c1_ack_drop",   32'(cart_ack), 32'd0);
    check("c1_mem_rd_low", 32'(mem_rd),   32'd0);
    check("c1_owner_rel",  32'(owner),    32'd1);
    wait_for(3, "c1_wait_idle");
    check("c1_rack_low", 32'(mem_rack), 32'd0);
    check("c1_idle_busy", 32'(busy),    32'd0);

    // Host write
    wlat = 4;
    host_addr = 32'h0080_0000; host_wdata = 16'hA5A5; host_wr = 1'b1;
    @(negedge clk);
    check("w_mem_wr",    32'(mem_wr),    32'd1);
    check("w_mem_waddr", mem_waddr,      32'h0080_0000);
    check("w_mem_wdata", 32'(mem_wdata), 32'h0000_A5A5);
    check("w_owner",     32'(owner),     32'd3);
    check("w_mem_rd",    32'(mem_rd),    32'd0);
    wait_for(1, "w_wait_ack");
    check("w_cart_ack",  32'(cart_ack),  32'd0);
    check("w_mem_wr_hold", 32'(mem_wr),  32'd1);
    host_wr = 1'b0;
    @(negedge clk);
    check("w_mem_wr_low", 32'(mem_wr),   32'd0);
    check("w_ack_low",    32'(host_ack), 32'd0);
    wait_for(3, "w_wait_idle");

    // Simultaneous cart and host reads: cart first, host right after release
    rlat = 2; rdata_val = 16'h1111;
    cart_addr = 32'h0000_0010; host_addr = 32'h0000_0020;
    cart_rd = 1'b1; host_rd = 1'b1;
    @(negedge clk);
    check("s_owner_cart", 32'(owner), 32'd1);
    check("s_raddr_cart", mem_raddr,  32'h0000_0010);
    wait_for(0, "s_wait_cart_ack");
    cart_rd = 1'b0; rdata_val = 16'h5555;
    @(negedge clk);
    check("s_rel_owner", 32'(owner), 32'd1);
    @(negedge clk);
    check("s_rel_rack",  32'(mem_rack), 32'd0);
    check("s_rel_owner2", 32'(owner),   32'd1);
    @(negedge clk);
    check("s_idle_owner", 32'(owner), 32'd0);
    @(negedge clk);
    check("s_owner_host", 32'(owner), 32'd2);
    check("s_raddr_host", mem_raddr,  32'h0000_0020);
    wait_for(1, "s_wait_host_ack");
    check("s_host_rdata", 32'(host_rdata), 32'h0000_5555);
    check("s_cart_data",  32'(cart_data),  32'h0000_1111);
    host_rd = 1'b0;
    wait_for(3, "s_wait_idle");

    // Starvation: host held while the cart re-requests back to back
    check("sv_cnt_start", 32'(dut.u_pick.starve_cnt), 32'd0);
    host_addr = 32'h0000_0040; cart_addr = 32'h0000_0044;
    host_rd = 1'b1; cart_rd = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_for(4, "sv_wait_grant");
      check("sv_owner", 32'(owner), (g < 4) ? 32'd1 : 32'd2);
      if (owner == 2'd1) begin
        wait_for(0, "sv_wait_cart_ack");
        cart_rd = 1'b0;
        wait_for(3, "sv_wait_idle");
        cart_rd = 1'b1;
      end
    end
    check("sv_cnt_cleared", 32'(dut.u_pick.starve_cnt), 32'd0);
    wait_for(1, "sv_wait_host_ack");
    check("sv_no_cart_ack", 32'(cart_ack), 32'd0);
    host_rd = 1'b0; cart_rd = 1'b0;
    wait_for(3, "sv_wait_end");

    // Early withdrawal during ISSUE
    rlat = 5; cart_addr = 32'h0000_0099; cart_rd = 1'b1;
    @(negedge clk);
    check("e_mem_rd", 32'(mem_rd), 32'd1);
    cart_rd = 1'b0;
    ack_seen = 1'b0; early = 1'b0; saw_rack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cart_ack) ack_seen = 1'b1;
      if (!mem_rd && !saw_rack) early = 1'b1;
      if (mem_rack) saw_rack = 1'b1;
    end
    check("e_no_cart_ack", 32'(ack_seen), 32'd0);
    check("e_rd_held",     32'(early),    32'd0);
    check("e_saw_rack",    32'(saw_rack), 32'd1);
    check("e_owner_idle",  32'(owner),    32'd0);
    check("e_busy_idle",   32'(busy),     32'd0);

    // Reset in HOLD while the controller keeps its write ack high
    wlat = 2; hold_wack = 1'b1;
    host_addr = 32'h0000_0100; host_wdata = 16'h1357; host_wr = 1'b1;
    wait_for(1, "r_wait_ack");
    check("r_wack_high", 32'(mem_wack), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("r_mem_wr",     32'(mem_wr),     32'd0);
    check("r_host_ack",   32'(host_ack),   32'd0);
    check("r_owner",      32'(owner),      32'd0);
    check("r_busy",       32'(busy),       32'd0);
    check("r_mem_waddr",  mem_waddr,       32'd0);
    check("r_mem_wdata",  32'(mem_wdata),  32'd0);
    check("r_host_rdata", 32'(host_rdata), 32'd0);
    check("r_cart_data",  32'(cart_data),  32'd0);
    reset = 1'b0;
    grant_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (owner != 2'd0 || mem_wr) grant_seen = 1'b1;
    end
    check("r_no_grant",     32'(grant_seen), 32'd0);
    check("r_wack_still",   32'(mem_wack),   32'd1);
    hold_wack = 1'b0;
    @(negedge clk);
    check("r_wack_dropped", 32'(mem_wack), 32'd0);
    check("r_owner_wait",   32'(owner),    32'd0);
    @(negedge clk);
    check("r_regrant_owner", 32'(owner),  32'd3);
    check("r_regrant_wr",    32'(mem_wr), 32'd1);
    check("r_regrant_addr",  mem_waddr,   32'h0000_0100);
    wait_for(1, "r_wait_ack2");
    host_wr = 1'b0;
    wait_for(3, "r_wait_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
